maxpool_22: RTL and testbench

- 2x2 max-pooling, stride 2, on the raster-order float32 pixel stream produced by conv_33.
- Sits directly downstream of the convolution stage. Consumes its pxl_out/valid_out pair and emits one pixel per non-overlapping 2x2 window, in raster order.
- Optional ReLU is applied on the output.
- No backpressure: the upstream stage cannot stall, so this block always accepts data.

---
 rtl/conv_pkg.sv | 19 +
 rtl/maxpool_22_fp_max.sv | 36 +++
 rtl/maxpool_22.sv | 98 +++++++++
 tb/tb_maxpool_22.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the conv/pool pipeline (float32 field layout, counter sizing).
package conv_pkg;

  localparam logic [31:0] FP_ZERO  = 32'h0000_0000;
  localparam int          SIGN_BIT = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;

  // Minimum 1 bit so degenerate sizes still yield a legal vector.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/maxpool_22_fp_max.sv
// Combinational IEEE-754 single-precision max of two operands; ties and +0/-0 return i_a.
module fp_max
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_max
);

  logic         w_sa;
  logic         w_sb;
  logic [30:0]  w_mag_a;
  logic [30:0]  w_mag_b;

  assign w_sa    = i_a[SIGN_BIT];
  assign w_sb    = i_b[SIGN_BIT];
  assign w_mag_a = {i_a[EXP_MSB:EXP_LSB], i_a[EXP_LSB-1:0]};
  assign w_mag_b = {i_b[EXP_MSB:EXP_LSB], i_b[EXP_LSB-1:0]};

  // Sign-magnitude ordering: negative operands compare with inverted magnitude.
  always_comb begin
    o_max = i_a;
    if ((i_a == i_b) || ((w_mag_a == '0) && (w_mag_b == '0))) begin
      o_max = i_a;
    end else if (w_sa != w_sb) begin
      o_max = w_sa ? i_b : i_a;
    end else if (!w_sa) begin
      o_max = (w_mag_b > w_mag_a) ? i_b : i_a;
    end else begin
      o_max = (w_mag_b < w_mag_a) ? i_b : i_a;
    end
  end

endmodule

// File: rtl/maxpool_22.sv
// 2x2 stride-2 float32 max-pool on a raster pixel stream; output registered 1 cycle after the
// 4th window pixel. Always accepts input (no backpressure); odd trailing row/column is dropped.
module maxpool_22
  import conv_pkg::*;
#(
  parameter int D          = 218,
  parameter int DATA_WIDTH = 32,
  parameter int RELU       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int HALF = D / 2;
  localparam int CW   = clog2(D);
  localparam int LW   = clog2(HALF);
  localparam bit ODD  = (D % 2) == 1;

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_linebuf [HALF];

  logic [LW-1:0]         w_lb_idx;
  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_in_win;
  logic                  w_last_win;
  logic [DATA_WIDTH-1:0] w_lb_rd;
  logic [DATA_WIDTH-1:0] w_pair;
  logic [DATA_WIDTH-1:0] w_win;
  logic [DATA_WIDTH-1:0] w_result;

  assign w_lb_idx   = LW'(r_col >> 1);
  assign w_col_last = (r_col == CW'(D - 1));
  assign w_row_last = (r_row == CW'(D - 1));
  assign w_in_win   = !(ODD && (w_col_last || w_row_last));
  assign w_last_win = (LW'(r_row >> 1) == LW'(HALF - 1)) && (w_lb_idx == LW'(HALF - 1));
  assign w_lb_rd    = r_linebuf[w_lb_idx];

  fp_max #(.DATA_WIDTH(DATA_WIDTH)) u_pair (
    .i_a   (r_hold),
    .i_b   (pxl_in),
    .o_max (w_pair)
  );

  fp_max #(.DATA_WIDTH(DATA_WIDTH)) u_win (
    .i_a   (w_lb_rd),
    .i_b   (w_pair),
    .o_max (w_win)
  );

  assign w_result = ((RELU != 0) && w_win[DATA_WIDTH-1]) ? DATA_WIDTH'(FP_ZERO) : w_win;

  // Even rows park the top-pair max here; odd rows read the same slot, so no port conflict.
  always_ff @(posedge clk) begin
    if (valid_in && w_in_win && !r_row[0] && r_col[0]) begin
      r_linebuf[w_lb_idx] <= w_pair;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col      <= '0;
      r_row      <= '0;
      r_hold     <= '0;
      pxl_out    <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_in_win) begin
          if (!r_col[0]) begin
            r_hold <= pxl_in;
          end else if (r_row[0]) begin
            pxl_out    <= w_result;
            valid_out  <= 1'b1;
            frame_done <= w_last_win;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_22.sv
// Bench: four maxpool_22 instances (D=4, D=2, D=2 ReLU, D=5) on a shared input stream, checked
// cycle by cycle against a window-level reference model plus directed known-answer checks.
module tb_maxpool_22;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pxl_in;
  logic [31:0] po [4];
  logic        vo [4];
  logic        fo [4];

  always #5 clk = ~clk;

  maxpool_22 #(.D(4), .DATA_WIDTH(32), .RELU(0)) u0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(po[0]), .valid_out(vo[0]), .frame_done(fo[0]));
  maxpool_22 #(.D(2), .DATA_WIDTH(32), .RELU(0)) u1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(po[1]), .valid_out(vo[1]), .frame_done(fo[1]));
  maxpool_22 #(.D(2), .DATA_WIDTH(32), .RELU(1)) u2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(po[2]), .valid_out(vo[2]), .frame_done(fo[2]));
  maxpool_22 #(.D(5), .DATA_WIDTH(32), .RELU(0)) u3 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pxl_in(pxl_in),
    .pxl_out(po[3]), .valid_out(vo[3]), .frame_done(fo[3]));

  int          DS [4] = '{4, 2, 2, 5};
  int          RL [4] = '{0, 0, 1, 0};
  int          mrow [4];
  int          mcol [4];
  logic [31:0] img [4][5][5];
  logic [31:0] e_dat [4];
  logic        e_vld [4];
  logic        e_fd [4];
  int          nout [4];
  int          nfd [4];
  logic [31:0] obs [4][16];
  int          total = 0;
  int          bad = 0;

  logic [31:0] case1 [16] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000,
                              32'h40400000, 32'h3F000000, 32'hBF800000, 32'hBF800000,
                              32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                              32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] case1_exp [4] = '{32'h40400000, 32'h3F000000, 32'h3F800000, 32'h3F800000};

  // Total order of float32 values as signed integers; +0 and -0 share key 0.
  function automatic longint fkey(input logic [31:0] x);
    return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
  endfunction

  function automatic logic [31:0] rmax(input logic [31:0] a, input logic [31:0] b);
    return (fkey(b) > fkey(a)) ? b : a;
  endfunction

  function automatic logic [31:0] itof(input int n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = (32'(n) << (23 - e)) & 32'h007FFFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  function automatic logic [31:0] rand_f();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)), 23'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("vld%0d", k), 32'(vo[k]), 32'(e_vld[k]));
      chk($sformatf("dat%0d", k), po[k], e_dat[k]);
      chk($sformatf("fd%0d", k), 32'(fo[k]), 32'(e_fd[k]));
      if (vo[k] === 1'b1) begin
        if (nout[k] < 16) obs[k][nout[k]] = po[k];
        nout[k]++;
      end
      if (fo[k] === 1'b1) nfd[k]++;
    end
  endtask

  task automatic model_accept(input logic [31:0] px);
    int d, r, c;
    logic [31:0] m;
    for (int k = 0; k < 4; k++) begin
      d = DS[k];
      r = mrow[k];
      c = mcol[k];
      img[k][r][c] = px;
      if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * (d / 2)) && (c < 2 * (d / 2))) begin
        m = rmax(rmax(img[k][r-1][c-1], img[k][r-1][c]), rmax(img[k][r][c-1], px));
        if (RL[k] != 0 && m[31]) m = 32'h0;
        e_dat[k] = m;
        e_vld[k] = 1'b1;
        e_fd[k]  = (r / 2 == d / 2 - 1) && (c / 2 == d / 2 - 1);
      end
      c++;
      if (c == d) begin
        c = 0;
        r = (r == d - 1) ? 0 : r + 1;
      end
      mrow[k] = r;
      mcol[k] = c;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mrow[k] = 0; mcol[k] = 0;
      e_dat[k] = 32'h0; e_vld[k] = 1'b0; e_fd[k] = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [31:0] px, input logic rst);
    @(negedge clk);
    check_outputs();
    reset    = rst;
    valid_in = v;
    pxl_in   = px;
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 4; k++) begin
        e_vld[k] = 1'b0;
        e_fd[k]  = 1'b0;
      end
      if (v) model_accept(px);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 4; k++) begin
      nout[k] = 0;
      nfd[k]  = 0;
    end
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; pxl_in = 32'h0;
    model_reset();
    clear_stats();

    // Reset state, then the basic D=4 window case.
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    clear_stats();
    for (int i = 0; i < 16; i++) step(1'b1, case1[i], 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("c1_count", 32'(nout[0]), 32'd4);
    chk("c1_fdcount", 32'(nfd[0]), 32'd1);
    for (int i = 0; i < 4; i++) chk($sformatf("c1_out%0d", i), obs[0][i], case1_exp[i]);

    // All-negative window, with and without ReLU.
    step(1'b0, 32'h0, 1'b1);
    clear_stats();
    step(1'b1, 32'hBF800000, 1'b0);
    step(1'b1, 32'hC0000000, 1'b0);
    step(1'b1, 32'hC0400000, 1'b0);
    step(1'b1, 32'hBF000000, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("neg_norelu", obs[1][0], 32'hBF000000);
    chk("neg_relu", obs[2][0], 32'h00000000);
    chk("neg_count", 32'(nout[1]), 32'd1);

    // Signed-zero ordering, then a mixed-sign frame back to back.
    step(1'b0, 32'h0, 1'b1);
    clear_stats();
    step(1'b1, 32'h80000000, 1'b0);
    step(1'b1, 32'h00000000, 1'b0);
    step(1'b1, 32'h80000000, 1'b0);
    step(1'b1, 32'h80000000, 1'b0);
    step(1'b1, 32'hBF800000, 1'b0);
    step(1'b1, 32'h3F000000, 1'b0);
    step(1'b1, 32'hBF800000, 1'b0);
    step(1'b1, 32'hBF800000, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("zero_order", obs[1][0], 32'h80000000);
    chk("mixed_sign", obs[1][1], 32'h3F000000);
    chk("zero_fdcount", 32'(nfd[1]), 32'd2);

    // Odd D=5 ramp: trailing column and row are dropped.
    step(1'b0, 32'h0, 1'b1);
    clear_stats();
    for (int n = 0; n < 25; n++) step(1'b1, itof(n), 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("odd_count", 32'(nout[3]), 32'd4);
    chk("odd_out0", obs[3][0], 32'h40C00000);
    chk("odd_out1", obs[3][1], 32'h41000000);
    chk("odd_out2", obs[3][2], 32'h41800000);
    chk("odd_out3", obs[3][3], 32'h41900000);
    chk("odd_fdcount", 32'(nfd[3]), 32'd1);

    // Random valid_in gaps must not change the pooled sequence.
    step(1'b0, 32'h0, 1'b1);
    clear_stats();
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 1) == 1) step(1'b0, $urandom, 1'b0);
      step(1'b1, case1[i], 1'b0);
    end
    step(1'b0, 32'h0, 1'b0);
    chk("gap_count", 32'(nout[0]), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("gap_out%0d", i), obs[0][i], case1_exp[i]);

    // Reset mid-frame, then two random frames back to back.
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, rand_f(), 1'b0);
    step(1'b1, rand_f(), 1'b1);
    step(1'b1, rand_f(), 1'b1);
    clear_stats();
    for (int i = 0; i < 32; i++) step(1'b1, rand_f(), 1'b0);
    step(1'b0, 32'h0, 1'b0);
    chk("b2b_count", 32'(nout[0]), 32'd8);
    chk("b2b_fdcount", 32'(nfd[0]), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
